// File: rtl/regfile_wb_arbiter_if.sv
// Register-file writeback arbiter bus.
//
// Groups the two writeback request channels, the registered write port that
// drives the register file, and the arbiter status signals.
//
// Handshake (both sources): a request transfers on a rising clk edge where
// v && rdy. Once v is raised, the source must hold v/rd/wd stable until that
// edge. rdy is combinational. It never depends on the same source's wd.
// A request to x0 (rd == 0) is accepted immediately and writes nothing.
//
//   v0/rd0/wd0/rdy0   source 0 (pipeline WB stage) request channel
//   v1/rd1/wd1/rdy1   source 1 (long-latency unit) request channel
//   RegWrite/A3/WD3   registered register-file write port
//   wsrc              source of the current registered write (0 or 1)
//   starved           source 1 has been denied STARVE_LIMIT cycles in a row
//   starve_cnt        starvation counter value (debug visibility)
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            v0;
    logic [4:0]      rd0;
    logic [XLEN-1:0] wd0;
    logic            rdy0;
    logic            v1;
    logic [4:0]      rd1;
    logic [XLEN-1:0] wd1;
    logic            rdy1;
    logic            RegWrite;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;
    logic            wsrc;
    logic            starved;
    logic [3:0]      starve_cnt;

    // Requesters plus register file side.
    modport master (
        output v0, rd0, wd0, v1, rd1, wd1,
        input  rdy0, rdy1, RegWrite, A3, WD3, wsrc, starved, starve_cnt
    );

    // Arbiter side.
    modport slave (
        input  v0, rd0, wd0, v1, rd1, wd1,
        output rdy0, rdy1, RegWrite, A3, WD3, wsrc, starved, starve_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
//
// Shares the single register-file write port between the pipeline WB stage
// (source 0, fixed priority) and a long-latency unit (source 1). Source 1 is
// forced through after it has lost STARVE_LIMIT consecutive cycles. The write
// port is registered: a request accepted at edge N appears on RegWrite/A3/WD3
// during cycle N+1 and the register file commits it at edge N+1.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   regfile_wb_arbiter_if.slave (request channels, write port, status)
//
// Parameters:
//   XLEN          write data width
//   STARVE_LIMIT  denied cycles tolerated before source 1 is forced (1..15)
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic            real0;
    logic            real1;
    logic            force1;
    logic            g0;
    logic            g1;
    logic [3:0]      starve_cnt_q;
    logic            regwrite_q;
    logic [4:0]      a3_q;
    logic [XLEN-1:0] wd3_q;
    logic            wsrc_q;

    // Only requests to a non-zero register compete for the port; x0 requests
    // are absorbed so they can never hold up the other source.
    assign real0  = bus.v0 && (bus.rd0 != 5'd0);
    assign real1  = bus.v1 && (bus.rd1 != 5'd0);

    // Counter at the limit means source 1 has already lost STARVE_LIMIT
    // cycles, so this cycle is the (STARVE_LIMIT+1)-th and it wins.
    assign force1 = (starve_cnt_q == LIMIT) && real1;
    assign g1     = real1 && (!real0 || force1);
    assign g0     = real0 && !force1;

    always_comb begin
        bus.rdy0       = (bus.v0 && (bus.rd0 == 5'd0)) || g0;
        bus.rdy1       = (bus.v1 && (bus.rd1 == 5'd0)) || g1;
        bus.starved    = (starve_cnt_q == LIMIT);
        bus.starve_cnt = starve_cnt_q;
        bus.RegWrite   = regwrite_q;
        bus.A3         = a3_q;
        bus.WD3        = wd3_q;
        bus.wsrc       = wsrc_q;
    end

    // Starvation counter: counts consecutive denied cycles of a real
    // source-1 request; any grant or absent request restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else if (real1 && !g1) begin
            if (starve_cnt_q != LIMIT) begin
                starve_cnt_q <= starve_cnt_q + 4'd1;
            end
        end else begin
            starve_cnt_q <= 4'd0;
        end
    end

    // Registered write port. Reset drops any write not yet committed.
    // A3/WD3 keep their last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            a3_q       <= 5'd0;
            wd3_q      <= '0;
            wsrc_q     <= 1'b0;
        end else begin
            regwrite_q <= g0 | g1;
            wsrc_q     <= g1;
            if (g1) begin
                a3_q  <= bus.rd1;
                wd3_q <= bus.wd1;
            end else if (g0) begin
                a3_q  <= bus.rd0;
                wd3_q <= bus.wd0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// arbitration rules and a scoreboard of expected register-file writes.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;
  localparam int W     = 1 + 5 + XLEN;  // {src, rd, wd}

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) ifc ();

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0]    exp_q[$];
  int              denied;       // consecutive cycles source 1 has lost
  logic [4:0]      held_a3;
  logic [XLEN-1:0] held_wd3;
  int              n_vec;
  int              n_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    denied   = 0;
    held_a3  = 5'd0;
    held_wd3 = '0;
  endtask

  // Registered outputs after an edge: at most one write per edge.
  task automatic check_regs();
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("RegWrite", 64'(ifc.RegWrite), 64'd1);
      chk("A3", 64'(ifc.A3), 64'(e[XLEN +: 5]));
      chk("WD3", 64'(ifc.WD3), 64'(e[XLEN-1:0]));
      chk("wsrc", 64'(ifc.wsrc), 64'(e[W-1]));
      held_a3  = e[XLEN +: 5];
      held_wd3 = e[XLEN-1:0];
    end else begin
      chk("RegWrite_idle", 64'(ifc.RegWrite), 64'd0);
      chk("A3_hold", 64'(ifc.A3), 64'(held_a3));
      chk("WD3_hold", 64'(ifc.WD3), 64'(held_wd3));
      chk("wsrc_idle", 64'(ifc.wsrc), 64'd0);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1. Drives the requests, checks the combinational
  // handshake mid-cycle, predicts the write, crosses the edge and checks.
  task automatic cycle(input logic v0, input logic [4:0] rd0, input logic [XLEN-1:0] wd0,
                       input logic v1, input logic [4:0] rd1, input logic [XLEN-1:0] wd1,
                       output logic acc0, output logic acc1);
    bit has0, has1, st, win1, win0;
    ifc.v0 = v0; ifc.rd0 = rd0; ifc.wd0 = wd0;
    ifc.v1 = v1; ifc.rd1 = rd1; ifc.wd1 = wd1;
    #2;
    has0 = v0 && (rd0 != 0);
    has1 = v1 && (rd1 != 0);
    st   = (denied == LIMIT);
    // Source 1 takes the port when source 0 has nothing to write, or when
    // it has already been passed over LIMIT times in a row.
    win1 = has1 && (!has0 || st);
    win0 = has0 && !win1;
    acc0 = (v0 && rd0 == 0) || win0;
    acc1 = (v1 && rd1 == 0) || win1;
    chk("rdy0", 64'(ifc.rdy0), 64'(acc0));
    chk("rdy1", 64'(ifc.rdy1), 64'(acc1));
    chk("starved", 64'(ifc.starved), 64'(st));
    chk("starve_cnt", 64'(ifc.starve_cnt), 64'(denied));
    if (win0) exp_q.push_back({1'b0, rd0, wd0});
    if (win1) exp_q.push_back({1'b1, rd1, wd1});
    if (has1 && !win1) denied = (denied + 1 > LIMIT) ? LIMIT : denied + 1;
    else denied = 0;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Asserts rst mid-cycle (inputs already driven) and releases it after an edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_RegWrite", 64'(ifc.RegWrite), 64'd0);
    chk("rst_A3", 64'(ifc.A3), 64'd0);
    chk("rst_WD3", 64'(ifc.WD3), 64'd0);
    chk("rst_starve_cnt", 64'(ifc.starve_cnt), 64'd0);
    chk("rst_starved", 64'(ifc.starved), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_edge_RegWrite", 64'(ifc.RegWrite), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a0, a1;
    logic p0, p1;
    logic [4:0] r0, r1;
    logic [XLEN-1:0] d0, d1;
    logic nv0, nv1;

    n_vec = 0;
    n_miss = 0;
    model_reset();
    rst = 1'b1;
    ifc.v0 = 1'b0; ifc.rd0 = '0; ifc.wd0 = '0;
    ifc.v1 = 1'b0; ifc.rd1 = '0; ifc.wd1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_RegWrite", 64'(ifc.RegWrite), 64'd0);
    chk("reset_A3", 64'(ifc.A3), 64'd0);
    chk("reset_WD3", 64'(ifc.WD3), 64'd0);
    chk("reset_wsrc", 64'(ifc.wsrc), 64'd0);
    chk("reset_starved", 64'(ifc.starved), 64'd0);
    ifc.v0 = 1'b1; ifc.rd0 = 5'd5;
    #1;
    chk("reset_rdy0", 64'(ifc.rdy0), 64'd1);
    @(posedge clk);
    #1;
    chk("reset_hold_RegWrite", 64'(ifc.RegWrite), 64'd0);
    rst = 1'b0;

    // Single write from source 0.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, a0, a1);
    chk("t1_A3", 64'(ifc.A3), 64'd5);

    // Both valid: source 0 first, then source 1.
    cycle(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, a0, a1);
    chk("t2_A3_first", 64'(ifc.A3), 64'd3);
    cycle(0, 5'd0, 0, 1, 5'd7, 32'h22, a0, a1);
    chk("t2_A3_second", 64'(ifc.A3), 64'd7);
    chk("t2_wsrc", 64'(ifc.wsrc), 64'd1);

    // Starvation: source 0 streams new writes, source 1 waits on x9.
    r0 = 5'd1;
    for (int i = 0; i < LIMIT + 1; i++) begin
      cycle(1, r0, 32'h100 + 32'(r0), 1, 5'd9, 32'h99, a0, a1);
      if (i < LIMIT) chk("t3_rdy1_low", 64'(a1), 64'd0);
      if (a0) r0 = r0 + 5'd1;
    end
    chk("t3_forced_A3", 64'(ifc.A3), 64'd9);
    chk("t3_cnt_cleared", 64'(ifc.starve_cnt), 64'd0);
    cycle(1, r0, 32'h100 + 32'(r0), 0, 5'd0, 0, a0, a1);

    // x0 discard alongside a real source-1 write.
    cycle(1, 5'd0, 32'hBAD, 1, 5'd4, 32'h44, a0, a1);
    chk("t4_A3", 64'(ifc.A3), 64'd4);
    chk("t4_WD3", 64'(ifc.WD3), 64'h44);

    // Reset with a non-zero starvation count and a write in flight.
    cycle(1, 5'd2, 32'h2, 1, 5'd12, 32'hC, a0, a1);
    cycle(1, 5'd3, 32'h3, 1, 5'd12, 32'hC, a0, a1);
    ifc.v0 = 1'b1; ifc.rd0 = 5'd4;
    mid_reset();
    // Reset just after source 1 was granted: its write never commits.
    cycle(0, 5'd0, 0, 1, 5'd12, 32'hC, a0, a1);
    ifc.v1 = 1'b0;
    mid_reset();

    // Idle after a write to x6.
    cycle(1, 5'd6, 32'h66, 0, 5'd0, 0, a0, a1);
    for (int i = 0; i < 3; i++) cycle(0, 5'd0, 0, 0, 5'd0, 0, a0, a1);
    chk("t6_A3_hold", 64'(ifc.A3), 64'd6);

    // Randomized traffic; each source holds its request until accepted.
    p0 = 1'b0; p1 = 1'b0;
    r0 = '0; r1 = '0; d0 = '0; d1 = '0; nv0 = 1'b0; nv1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        nv0 = ($urandom_range(0, 9) < 7);
        r0  = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d0  = $urandom;
      end
      if (!p1) begin
        nv1 = ($urandom_range(0, 9) < 5);
        r1  = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d1  = $urandom;
      end
      cycle(nv0, r0, d0, nv1, r1, d1, a0, a1);
      p0 = nv0 && !a0;
      p1 = nv1 && !a1;
    end
    cycle(0, 5'd0, 0, 0, 5'd0, 0, a0, a1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/A3/WD3) between two writeback sources.
- Source 0 is the pipeline WB stage. Source 1 is a long-latency unit, e.g. mul/div or load-miss return.
- Fixed priority to source 0, with a starvation counter that forces a grant to source 1 after STARVE_LIMIT lost cycles.
- Sits between the WB stage / long-latency unit and the register file. The write outputs are registered, giving 1-cycle latency into the register file.

Parameters:
- XLEN, 32, data width of write data.
- STARVE_LIMIT, 4, consecutive cycles source 1 may be denied before it is forced through. Legal range is 1 to 15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- v0  input  1  source 0 (WB stage) write request valid.
- rd0  input  5  source 0 destination register.
- wd0  input  XLEN  source 0 write data.
- rdy0  output  1  source 0 request accepted this cycle (combinational).
- v1  input  1  source 1 (long-latency unit) write request valid.
- rd1  input  5  source 1 destination register.
- wd1  input  XLEN  source 1 write data.
- rdy1  output  1  source 1 request accepted this cycle (combinational).
- RegWrite  output  1  register-file write enable (registered).
- A3  output  5  register-file write address (registered).
- WD3  output  XLEN  register-file write data (registered).
- wsrc  output  1  source of the current registered write: 0 or 1.
- starved  output  1  high while starve_cnt == STARVE_LIMIT.

Behaviour:
- Handshake: a request transfers on a clock edge where v && rdy. A source must hold v/rd/wd stable until accepted. rdy never depends on the same source's wd.
- x0 requests (rd == 0) are discarded without using the port: rdy = v, no write issued. Such requests never block the other source.
- A "real" request is v && rd != 0.
- Grant, combinational:
  - force1 = starved && real1.
  - g1 = real1 && (!real0 || force1).
  - g0 = real0 && !force1.
  - rdy0 = (v0 && rd0 == 0) || g0.
  - rdy1 = (v1 && rd1 == 0) || g1.
- Output register, on each posedge clk (not in reset):
  - RegWrite <= g0 | g1.
  - A3/WD3 <= the granted source's rd/wd. They hold their previous value when no grant.
  - wsrc <= g1.
- Latency: accepted at edge N, so RegWrite/A3/WD3 are valid in cycle N+1 and the register file writes at edge N+1.
- Starvation counter starve_cnt, width 4:
  - Increments (saturating at STARVE_LIMIT) each cycle where real1 && !g1.
  - Clears to 0 in any cycle with g1 or !real1.
  - starved = (starve_cnt == STARVE_LIMIT). The forced grant therefore occurs on the (STARVE_LIMIT+1)-th cycle of continuous denial.
  - A forced grant lasts exactly one transfer, then the counter restarts from 0.
- Simultaneous real requests, same rd: only one is granted per cycle, and writes land in grant order. Program order between sources is the requesters' responsibility; the arbiter does not reorder or merge.
- Both sources idle or both x0: RegWrite = 0 next cycle; A3/WD3 keep their old values.
- Reset values, async on rst high:
  - RegWrite = 0, A3 = 0, WD3 = 0, wsrc = 0, starve_cnt = 0, starved = 0.
  - rdy0/rdy1 follow the combinational rules using starve_cnt = 0.
- Reset mid-operation: a write registered but not yet committed is dropped, and RegWrite is forced low immediately. Requests pending at deassertion are re-arbitrated from a cleared counter.
- No FSM beyond the counter. The two effective modes are PRIO0 (starved = 0) and FORCE1 (starved = 1 && real1). FORCE1 lasts one cycle when real1 is present.

Test Plan:
- After reset, v0 = 1, rd0 = 5, wd0 = 0xDEADBEEF, v1 = 0 -> rdy0 = 1; next cycle RegWrite = 1, A3 = 5, WD3 = 0xDEADBEEF, wsrc = 0.
- Both valid: rd0 = 3 (0x11), rd1 = 7 (0x22) -> cycle 1 grants source 0 (A3 = 3). With v0 dropped after that, cycle 2 grants source 1 (A3 = 7, wsrc = 1).
- Starvation, STARVE_LIMIT = 4: v0 held high with new rd each cycle, v1 = 1, rd1 = 9 -> rdy1 low for 4 cycles, starved = 1 on cycle 5 with rdy1 = 1 and rdy0 = 0. A3 = 9 the following cycle, then starve_cnt = 0.
- x0 discard: v0 = 1, rd0 = 0 and v1 = 1, rd1 = 4 (0x44) in the same cycle -> rdy0 = 1 and rdy1 = 1; next cycle RegWrite = 1, A3 = 4, WD3 = 0x44. No write for rd0.
- Reset mid-operation: grant source 1 (rd1 = 12), assert rst asynchronously before the next edge -> RegWrite falls to 0 immediately, starve_cnt = 0, and no write to x12 reaches the register file.
- Idle: v0 = v1 = 0 for 3 cycles after a write to A3 = 6 -> RegWrite = 0; A3 stays 6 and WD3 keeps its value.
